// File: rtl/hyperbus_wb_bridge_pkg.sv
// Shared definitions for the Wishbone-to-HyperBus word bridge.
package hyperbus_wb_bridge_pkg;

  localparam int HB_WORD_W = 16;

  // RWDS mask polarity: a set bit means the byte is NOT written.
  localparam logic MASK_ON = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_WR1,
    ST_RD0,
    ST_RD1,
    ST_ACK,
    ST_ERR
  } state_t;

  function automatic logic [1:0] rwds_mask(input logic [1:0] sel);
    return MASK_ON ? ~sel : sel;
  endfunction

endpackage

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic slave that splits each 32-bit access into two
// 16-bit HyperBus controller words (one word for register space).
module hyperbus_wb_bridge
  import hyperbus_wb_bridge_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int REG_SPACE_BIT = 31,
  parameter int TIMEOUT       = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [ADDR_W-1:0]    hb_adr_o,
  output logic [HB_WORD_W-1:0] hb_dat_o,
  output logic [2:0]           hb_mask_o,
  output logic                 hb_reg_space_o,
  output logic                 hb_wrq_o,
  output logic                 hb_rrq_o,
  input  logic [HB_WORD_W-1:0] hb_dat_i,
  input  logic                 hb_ready_i,
  input  logic                 hb_valid_i,
  input  logic                 hb_busy_i,
  input  logic                 hb_error_i
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   hb_adr_reg;
  logic [31:0]         dat_reg;
  logic [3:0]          sel_reg;
  logic                reg_space_reg;
  logic [31:0]         rdat_reg;
  logic [TO_W-1:0]     to_cnt_reg;

  logic [ADDR_W-1:0]   adr_clr;
  logic                accept;
  logic                in_wr;
  logic                in_rd;
  logic                word_done;
  logic                timed_out;
  logic                unused_adr;

  assign unused_adr = wb_adr_i[0];

  always_comb begin
    adr_clr                = wb_adr_i;
    adr_clr[REG_SPACE_BIT] = 1'b0;
  end

  assign in_wr     = (state_reg == ST_WR0) || (state_reg == ST_WR1);
  assign in_rd     = (state_reg == ST_RD0) || (state_reg == ST_RD1);
  assign word_done = (in_wr && hb_ready_i) || (in_rd && hb_valid_i);
  assign timed_out = (to_cnt_reg == TO_W'(TIMEOUT - 1));
  assign accept    = (state_reg == ST_IDLE) && wb_cyc_i && wb_stb_i &&
                     !hb_error_i && !hb_busy_i;

  // A word accepted on the same cycle as timeout/error still counts.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (hb_error_i)      state_next = ST_ERR;
          else if (!hb_busy_i) state_next = wb_we_i ? ST_WR0 : ST_RD0;
        end
      end
      ST_WR0: begin
        if (hb_ready_i)                    state_next = reg_space_reg ? ST_ACK : ST_WR1;
        else if (hb_error_i || timed_out)  state_next = ST_ERR;
      end
      ST_WR1: begin
        if (hb_ready_i)                    state_next = ST_ACK;
        else if (hb_error_i || timed_out)  state_next = ST_ERR;
      end
      ST_RD0: begin
        if (hb_valid_i)                    state_next = reg_space_reg ? ST_ACK : ST_RD1;
        else if (hb_error_i || timed_out)  state_next = ST_ERR;
      end
      ST_RD1: begin
        if (hb_valid_i)                    state_next = ST_ACK;
        else if (hb_error_i || timed_out)  state_next = ST_ERR;
      end
      ST_ACK:  state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      hb_adr_reg    <= '0;
      dat_reg       <= '0;
      sel_reg       <= '0;
      reg_space_reg <= 1'b0;
      rdat_reg      <= '0;
      to_cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        hb_adr_reg    <= {1'b0, adr_clr[ADDR_W-1:1]};
        dat_reg       <= wb_dat_i;
        sel_reg       <= wb_sel_i;
        reg_space_reg <= wb_adr_i[REG_SPACE_BIT];
      end
      if (accept || word_done)
        to_cnt_reg <= '0;
      else if (in_wr || in_rd)
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      if (state_reg == ST_RD0 && hb_valid_i) begin
        rdat_reg[15:0] <= hb_dat_i;
        if (reg_space_reg)
          rdat_reg[31:16] <= '0;
      end
      if (state_reg == ST_RD1 && hb_valid_i)
        rdat_reg[31:16] <= hb_dat_i;
    end
  end

  always_comb begin
    hb_dat_o  = '0;
    hb_mask_o = '0;
    if (state_reg == ST_WR0) begin
      hb_dat_o  = dat_reg[15:0];
      hb_mask_o = {1'b0, rwds_mask(sel_reg[1:0])};
    end else if (state_reg == ST_WR1) begin
      hb_dat_o  = dat_reg[31:16];
      hb_mask_o = {1'b0, rwds_mask(sel_reg[3:2])};
    end
  end

  assign hb_wrq_o       = in_wr;
  assign hb_rrq_o       = in_rd;
  assign hb_adr_o       = hb_adr_reg;
  assign hb_reg_space_o = reg_space_reg && (in_wr || in_rd);
  assign wb_dat_o       = rdat_reg;
  // An abandoned bus cycle still drains the burst but gets no ack.
  assign wb_ack_o       = (state_reg == ST_ACK) && wb_cyc_i;
  assign wb_err_o       = (state_reg == ST_ERR);

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Randomized bench for hyperbus_wb_bridge with a transaction-level model
// of the expected HyperBus words and Wishbone responses.
module tb_hyperbus_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] hb_adr_o;
  logic [15:0] hb_dat_o;
  logic [2:0]  hb_mask_o;
  logic        hb_reg_space_o;
  logic        hb_wrq_o;
  logic        hb_rrq_o;
  logic [15:0] hb_dat_i = '0;
  logic        hb_ready_i = 1'b0;
  logic        hb_valid_i = 1'b0;
  logic        hb_busy_i = 1'b0;
  logic        hb_error_i = 1'b0;

  hyperbus_wb_bridge #(.ADDR_W(32), .REG_SPACE_BIT(31), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .hb_adr_o(hb_adr_o), .hb_dat_o(hb_dat_o), .hb_mask_o(hb_mask_o),
    .hb_reg_space_o(hb_reg_space_o), .hb_wrq_o(hb_wrq_o), .hb_rrq_o(hb_rrq_o),
    .hb_dat_i(hb_dat_i), .hb_ready_i(hb_ready_i), .hb_valid_i(hb_valid_i),
    .hb_busy_i(hb_busy_i), .hb_error_i(hb_error_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [2:0]  mask;
    bit          rs;
    bit          last;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_words[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          mode = 0;        // 0 random controller, 1 stalled, 2 driven by hand
  bit          err_allowed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_push(input bit we, input logic [31:0] adr, input logic [15:0] dat,
                          input logic [2:0] mask, input bit rs, input bit last,
                          input logic [31:0] rdata);
    exp_t e;
    e.we = we; e.adr = adr; e.dat = dat; e.mask = mask;
    e.rs = rs; e.last = last; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Expected words of one access, derived directly from the bridge rules.
  task automatic model_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [15:0] w0, input logic [15:0] w1);
    bit          rs;
    logic [31:0] a;
    logic [31:0] rdata;
    int          n;
    rs    = adr[31];
    a     = adr & 32'h7FFF_FFFF;
    n     = rs ? 1 : 2;
    rdata = rs ? {16'h0000, w0} : {w1, w0};
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      logic [1:0]  s;
      d = (i == 0) ? dat[15:0] : dat[31:16];
      s = (i == 0) ? sel[1:0] : sel[3:2];
      exp_push(we, a / 2, we ? d : 16'h0, we ? {1'b0, ~s} : 3'b000, rs, i == n - 1, rdata);
    end
    if (!we) begin
      rd_words.push_back(w0);
      if (!rs) rd_words.push_back(w1);
    end
  endtask

  // Emulated HyperBus controller.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mode == 0) begin
        hb_ready_i = hb_wrq_o && ($urandom_range(0, 2) != 0);
        hb_valid_i = 1'b0;
        if (hb_rrq_o && ($urandom_range(0, 2) != 0) && rd_words.size() > 0) begin
          hb_valid_i = 1'b1;
          hb_dat_i   = rd_words.pop_front();
        end else begin
          hb_dat_i = 16'($urandom);
        end
        hb_busy_i = (hb_wrq_o || hb_rrq_o) ? 1'b1 : ($urandom_range(0, 3) == 0);
      end else if (mode == 1) begin
        hb_ready_i = 1'b0;
        hb_valid_i = 1'b0;
        hb_busy_i  = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  bit          ack_due, due_rd;
  logic [31:0] due_rdata;
  bit          prev_cs, prev_busy, prev_errin, prev_req, prev_ack, prev_errout;
  bit          req_now;
  exp_t        cur;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_due = 0; prev_cs = 0; prev_busy = 0; prev_errin = 0;
        prev_req = 0; prev_ack = 0; prev_errout = 0;
      end else begin
        req_now = hb_wrq_o || hb_rrq_o;
        if (ack_due) begin
          check("ack_after_last_word", wb_ack_o, wb_cyc_i);
          check("req_low_after_last", req_now, 0);
          if (due_rd && wb_cyc_i) check("read_data", wb_dat_o, due_rdata);
          ack_due = 0;
        end else begin
          check("no_spurious_ack", wb_ack_o, 0);
        end
        if (!err_allowed) check("no_spurious_err", wb_err_o, 0);
        if (!prev_req && req_now) check("req_not_while_busy", prev_busy, 0);
        if (prev_cs && !prev_busy && !prev_errin && !prev_req && !prev_ack && !prev_errout)
          check("req_latency", req_now, 1);
        if ((hb_wrq_o && hb_ready_i) || (hb_rrq_o && hb_valid_i)) begin
          check("word_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("word_dir", hb_wrq_o, cur.we);
            check("hb_adr", hb_adr_o, cur.adr);
            check("hb_reg_space", hb_reg_space_o, cur.rs);
            if (cur.we) begin
              check("hb_dat", hb_dat_o, cur.dat);
              check("hb_mask", hb_mask_o, cur.mask);
            end
            if (cur.last) begin
              ack_due   = 1;
              due_rd    = !cur.we;
              due_rdata = cur.rdata;
            end
          end
        end
        prev_cs     = wb_cyc_i && wb_stb_i;
        prev_busy   = hb_busy_i;
        prev_errin  = hb_error_i;
        prev_req    = req_now;
        prev_ack    = wb_ack_o;
        prev_errout = wb_err_o;
      end
    end
  end

  int txn_id = 0;

  task automatic wb_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit abort);
    bit done;
    int cnt;
    int drop_at;
    @(posedge clk); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    drop_at = $urandom_range(0, 2);
    done = 0;
    cnt = 0;
    while (!done && cnt < 500) begin
      @(negedge clk);
      cnt++;
      if (wb_ack_o || wb_err_o) done = 1;
      else if (abort && (hb_wrq_o || hb_rrq_o)) begin
        if (drop_at == 0) done = 1;
        else drop_at--;
      end
    end
    check("wb_response_in_time", done, 1);
    @(posedge clk); #1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    if (abort) begin
      cnt = 0;
      do begin @(negedge clk); cnt++; end
      while ((exp_q.size() > 0 || hb_wrq_o || hb_rrq_o) && cnt < 500);
      check("abort_drained", exp_q.size(), 0);
      repeat (2) @(negedge clk);
    end
    $display("txn %0d we=%0b adr=%08h dat=%08h sel=%h abort=%0b rdata=%08h",
             txn_id, we, adr, dat, sel, abort, wb_dat_o);
    txn_id++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int          k;
  bit          r_we, r_abort;
  logic [31:0] r_adr, r_dat;
  logic [3:0]  r_sel;
  logic [15:0] r_w0, r_w1;

  initial begin
    #23;
    check("reset_wb_outs", {wb_dat_o[29:0], wb_ack_o, wb_err_o}, 0);
    check("reset_hb_outs", {hb_adr_o[7:0], hb_dat_o, hb_mask_o, hb_reg_space_o,
                            hb_wrq_o, hb_rrq_o, wb_dat_o[31:30]}, 0);
    check("reset_hb_adr", hb_adr_o, 0);
    @(negedge clk); rst = 0;

    // Directed: full-word write, byte-masked write, memory read, register read.
    exp_push(1, 32'h80, 16'h5678, 3'b000, 0, 0, 0);
    exp_push(1, 32'h80, 16'h1234, 3'b000, 0, 1, 0);
    wb_txn(1, 32'h0000_0100, 32'h1234_5678, 4'b1111, 0);
    exp_push(1, 32'h20, 16'hF00D, 3'b011, 0, 0, 0);
    exp_push(1, 32'h20, 16'hCAFE, 3'b010, 0, 1, 0);
    wb_txn(1, 32'h0000_0040, 32'hCAFE_F00D, 4'b0100, 0);
    rd_words.push_back(16'hBEEF); rd_words.push_back(16'hDEAD);
    exp_push(0, 32'h100, 0, 0, 0, 0, 32'hDEAD_BEEF);
    exp_push(0, 32'h100, 0, 0, 0, 1, 32'hDEAD_BEEF);
    wb_txn(0, 32'h0000_0200, 32'h0, 4'hF, 0);
    rd_words.push_back(16'h8F1F);
    exp_push(0, 32'h8, 0, 0, 1, 1, 32'h0000_8F1F);
    wb_txn(0, 32'h8000_0010, 32'h0, 4'hF, 0);

    // Directed: controller stalls, request times out after 16 cycles.
    mode = 1; err_allowed = 1;
    @(posedge clk); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h300; wb_sel_i = 4'hF;
    k = 0;
    do begin @(negedge clk); k++; end while (!hb_wrq_o && k < 10);
    k = 0;
    while (hb_wrq_o && k < 100) begin @(negedge clk); k++; end
    check("timeout_cycles", k, 16);
    check("timeout_err", wb_err_o, 1);
    check("timeout_wrq_dropped", hb_wrq_o, 0);
    @(posedge clk); #1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    @(negedge clk);
    check("timeout_err_one_cycle", wb_err_o, 0);

    // Directed: sticky controller error blocks a new request.
    @(posedge clk); #1;
    hb_error_i = 1; wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h400;
    @(negedge clk);
    check("error_no_req", hb_wrq_o | hb_rrq_o, 0);
    @(negedge clk);
    check("error_err_pulse", wb_err_o, 1);
    check("error_no_req2", hb_wrq_o | hb_rrq_o, 0);
    @(posedge clk); #1; wb_cyc_i = 0; wb_stb_i = 0; hb_error_i = 0;
    @(negedge clk);
    check("error_err_one_cycle", wb_err_o, 0);
    err_allowed = 0;

    // Directed: reset mid-read drops the request immediately.
    @(posedge clk); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h500;
    k = 0;
    do begin @(negedge clk); k++; end while (!hb_rrq_o && k < 10);
    check("rst_read_started", hb_rrq_o, 1);
    repeat (3) @(negedge clk);
    rst = 1; #1;
    check("rst_rrq_async", hb_rrq_o, 0);
    check("rst_outs_zero", {hb_wrq_o, hb_adr_o[30:0], wb_ack_o, wb_err_o}, 0);
    wb_cyc_i = 0; wb_stb_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    mode = 0;

    // Directed: word accepted on the last timeout cycle wins over the timeout.
    mode = 2; hb_ready_i = 0; hb_valid_i = 0; hb_busy_i = 0;
    model_txn(1, 32'h0000_0400, 32'hA5A5_5A5A, 4'hF, 0, 0);
    fork
      wb_txn(1, 32'h0000_0400, 32'hA5A5_5A5A, 4'hF, 0);
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!hb_wrq_o && k < 10);
        repeat (15) @(posedge clk);
        #1 hb_ready_i = 1;
        #2 mode = 0;
      end
    join

    // Randomized traffic, including register space and abandoned cycles.
    for (int t = 0; t < 150; t++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_adr   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) != 0) r_adr[31] = 1'b0;
      r_dat   = $urandom;
      r_sel   = 4'($urandom_range(0, 15));
      r_w0    = 16'($urandom);
      r_w1    = 16'($urandom);
      r_abort = ($urandom_range(0, 7) == 0);
      model_txn(r_we, r_adr, r_dat, r_sel, r_w0, r_w1);
      wb_txn(r_we, r_adr, r_dat, r_sel, r_abort);
    end

    repeat (4) @(negedge clk);
    check("model_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
